// File: rtl/nest_checker_pkg.sv
// Shared types and helpers for the begin/end nesting checker.
//   - match_state_e : keyword matcher state encoding
//   - Ch*           : ASCII constants used by the matcher
//   - is_word_char  : identifier-character classifier
//   - fold_char     : lower-cases letters, passes everything else through
package nest_checker_pkg;

  typedef enum logic [3:0] {
    StDelim,
    StB,
    StBe,
    StBeg,
    StBegi,
    StBegin,
    StE,
    StEn,
    StEnd,
    StOther
  } match_state_e;

  localparam logic [7:0] ChB     = 8'h62;  // 'b'
  localparam logic [7:0] ChE     = 8'h65;  // 'e'
  localparam logic [7:0] ChG     = 8'h67;  // 'g'
  localparam logic [7:0] ChI     = 8'h69;  // 'i'
  localparam logic [7:0] ChN     = 8'h6e;  // 'n'
  localparam logic [7:0] ChD     = 8'h64;  // 'd'
  localparam logic [7:0] Ch0     = 8'h30;  // '0'
  localparam logic [7:0] Ch9     = 8'h39;  // '9'
  localparam logic [7:0] ChLowA  = 8'h61;  // 'a'
  localparam logic [7:0] ChLowZ  = 8'h7a;  // 'z'
  localparam logic [7:0] ChUnder = 8'h5f;  // '_'
  localparam logic [7:0] CaseBit = 8'h20;

  // OR-ing the case bit maps 'A'-'Z' onto 'a'-'z' and never lands a
  // non-letter inside 'a'-'z', so one range test covers both cases.
  function automatic logic is_letter(input logic [7:0] c);
    logic [7:0] l;
    l = c | CaseBit;
    return (l >= ChLowA) && (l <= ChLowZ);
  endfunction

  function automatic logic is_word_char(input logic [7:0] c);
    return is_letter(c) || ((c >= Ch0) && (c <= Ch9)) || (c == ChUnder);
  endfunction

  function automatic logic [7:0] fold_char(input logic [7:0] c);
    return is_letter(c) ? (c | CaseBit) : c;
  endfunction

endpackage

// File: rtl/kw_matcher.sv
// Keyword prefix matcher for "begin" / "end" on a lower-cased character stream.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   clear            : synchronous return to the delimiter state
//   valid, ch        : accepted (already folded) character
//   commit_begin/end : combinational pulse when a delimiter terminates the keyword
//   pend_begin/end   : registered decode, a complete keyword is in progress
module kw_matcher
  import nest_checker_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       valid,
  input  logic [7:0] ch,
  output logic       commit_begin,
  output logic       commit_end,
  output logic       pend_begin,
  output logic       pend_end
);

  match_state_e state_q, state_d;
  logic         word;

  assign word = is_word_char(ch);

  // Advance along a keyword prefix when the expected letter arrives.
  function automatic match_state_e step(input logic w, input logic [7:0] c,
                                        input logic [7:0] want, input match_state_e nxt);
    if (!w)              return StDelim;
    else if (c == want)  return nxt;
    else                 return StOther;
  endfunction

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StDelim;
    end else if (valid) begin
      unique case (state_q)
        StDelim: begin
          if (!word)           state_d = StDelim;
          else if (ch == ChB)  state_d = StB;
          else if (ch == ChE)  state_d = StE;
          else                 state_d = StOther;
        end
        StB:     state_d = step(word, ch, ChE, StBe);
        StBe:    state_d = step(word, ch, ChG, StBeg);
        StBeg:   state_d = step(word, ch, ChI, StBegi);
        StBegi:  state_d = step(word, ch, ChN, StBegin);
        StE:     state_d = step(word, ch, ChN, StEn);
        StEn:    state_d = step(word, ch, ChD, StEnd);
        StBegin, StEnd, StOther: state_d = word ? StOther : StDelim;
        default: state_d = StDelim;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StDelim;
    end else begin
      state_q <= state_d;
    end
  end

  assign pend_begin   = (state_q == StBegin);
  assign pend_end     = (state_q == StEnd);
  assign commit_begin = valid && !clear && !word && pend_begin;
  assign commit_end   = valid && !clear && !word && pend_end;

endmodule

// File: rtl/nest_checker.sv
// Streaming begin/end nesting checker.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   clear          : synchronous clear, drops any character on the same cycle
//   in_valid, in   : one ASCII character per accepted cycle
//   result         : stream so far (word in progress treated as terminated) is balanced
//   depth          : committed nesting depth
//   err_underflow  : sticky, an "end" was committed at depth 0
//   err_overflow   : sticky, a "begin" was committed at MAX_DEPTH
module nest_checker
  import nest_checker_pkg::*;
#(
  parameter int unsigned DEPTH_W   = 16,
  parameter int unsigned MAX_DEPTH = 2 ** DEPTH_W - 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_underflow,
  output logic               err_overflow
);

  localparam logic [DEPTH_W-1:0] MaxDepth = DEPTH_W'(MAX_DEPTH);

  logic               commit_begin, commit_end, pend_begin, pend_end;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_u_q, err_u_d, err_o_q, err_o_d;
  logic               frozen;
  logic signed [DEPTH_W:0] eff;

  kw_matcher u_matcher (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .valid        (in_valid),
    .ch           (fold_char(in)),
    .commit_begin (commit_begin),
    .commit_end   (commit_end),
    .pend_begin   (pend_begin),
    .pend_end     (pend_end)
  );

  // After any error the depth no longer means anything, so it is held.
  assign frozen = err_u_q || err_o_q;

  always_comb begin
    depth_d = depth_q;
    err_u_d = err_u_q;
    err_o_d = err_o_q;
    if (clear) begin
      depth_d = '0;
      err_u_d = 1'b0;
      err_o_d = 1'b0;
    end else if (!frozen) begin
      if (commit_begin) begin
        if (depth_q < MaxDepth) depth_d = depth_q + 1'b1;
        else                    err_o_d = 1'b1;
      end else if (commit_end) begin
        if (depth_q != '0) depth_d = depth_q - 1'b1;
        else               err_u_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_q <= '0;
      err_u_q <= 1'b0;
      err_o_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      err_u_q <= err_u_d;
      err_o_q <= err_o_d;
    end
  end

  // Depth as if the word in progress were terminated now; one extra bit so a
  // pending begin at the counter's top does not wrap back to zero.
  always_comb begin
    eff = $signed({1'b0, depth_q})
        + $signed({{DEPTH_W{1'b0}}, pend_begin})
        - $signed({{DEPTH_W{1'b0}}, pend_end});
  end

  assign result        = !err_u_q && !err_o_q && (eff == '0);
  assign depth         = depth_q;
  assign err_underflow = err_u_q;
  assign err_overflow  = err_o_q;

endmodule

// File: doc/nest_checker.md
# nest_checker

Streaming keyword-nesting checker: consumes one ASCII character per accepted cycle and tracks `begin`/`end` nesting with case-insensitive, identifier-delimited keyword matching. It generalises the fixed 16-bit begin/end checker with these additions: parametrised depth, a valid qualifier and a synchronous clear. It also reports overflow and underflow separately and exposes live depth. It sits after the character source in the text-processing datapath; `result` feeds the top-level status.

## Interface
- `DEPTH_W`, 16, width of the nesting counter.
- `MAX_DEPTH`, 2**DEPTH_W-1, highest legal nesting depth; 1 ≤ MAX_DEPTH ≤ 2**DEPTH_W-1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `clear`  in  1  synchronous clear; same effect as reset, one cycle.
- `in_valid`  in  1  `in` carries a character this cycle.
- `in`  in  8  ASCII character.
- `result`  out  1  stream so far is balanced and error-free.
- `depth`  out  DEPTH_W  committed nesting depth.
- `err_underflow`  out  1  sticky: an `end` was committed at depth 0.
- `err_overflow`  out  1  sticky: a `begin` was committed at depth MAX_DEPTH.

## Operation
- Word character: `A-Z`, `a-z`, `0-9`, `_`. Every other byte is a delimiter. Letters are folded to lower case (`in | 8'h20` for letters only).
- A word is a maximal run of word characters. It is committed when the first delimiter after it is accepted.
- Matcher FSM states:
  - `DELIM`: last accepted character was a delimiter. This is the reset state.
  - Prefix states `B`, `BE`, `BEG`, `BEGI`, `BEGIN`, `E`, `EN`, `END`.
  - `OTHER`: the current word cannot be a keyword.
- Matcher transitions:
  - From `DELIM`: `b` → `B`, `e` → `E`, any other word character → `OTHER`, delimiter → `DELIM`.
  - From a prefix state: the expected next letter advances to the next prefix state; any other word character → `OTHER`; a delimiter commits the word → `DELIM`.
  - From `BEGIN` or `END`: any word character → `OTHER` (e.g. `beginx`, `end2`).
- Commit, when a delimiter is accepted:
  - In `BEGIN`: if depth < MAX_DEPTH, depth+1. Otherwise set `err_overflow` and hold depth.
  - In `END`: if depth > 0, depth−1. Otherwise set `err_underflow` and hold depth.
  - In any other state: no depth change.
- Tentative evaluation: the word in progress is treated as if it were terminated now.
  - eff = depth + (state==BEGIN) − (state==END), computed at DEPTH_W+1 bits signed.
  - `result` = !err_underflow && !err_overflow && eff==0.
  - A pending `END` at depth 0 therefore gives `result`=0. A pending `BEGIN` at MAX_DEPTH gives `result`=0 because eff ≠ 0.
- Once either error flag is set:
  - Depth freezes and later commits are ignored.
  - The matcher keeps running.
  - Both flags stay set until reset or `clear`.
- Cycles with `in_valid`=0 change nothing.
- Priority: `reset_n` low > `clear` > `in_valid`.

## Timing
- Reset values: state `DELIM`, `depth`=0, `err_underflow`=0, `err_overflow`=0, `result`=1.
- Outputs are decoded combinationally from registers only; there is no input-to-output combinational path.
- Latency 1: the character accepted at edge N is reflected in all outputs after edge N.
- Throughput 1 character per cycle; no backpressure.
- Reset asserted mid-word or mid-stream: all state returns to reset values immediately. The first character after release is treated as following a delimiter.
- `clear` together with `in_valid`: the character is dropped and the reset state is loaded.
- The stream start behaves as a delimiter, so a leading `begin` counts.

## Structure
- Package `nest_checker_pkg`:
  - Matcher state enum.
  - ASCII constants: `b e g i n d`, `0`, `9`, `a`, `z`, `_`.
  - Function `is_word_char`.
- Sub-module `kw_matcher`: takes the folded character and valid, and outputs:
  - `commit_begin`, `commit_end` (one-cycle pulses, combinational on the accepting cycle);
  - `pend_begin`, `pend_end` (registered state decode).
- The top level holds the depth counter, the error flags and the `result` decode.

## Test plan
- Reset, then `BEGIN x End ` (mixed case) → depth 1 after the first delimiter, 0 after the final space; `result` ends at 1; no errors.
- `end ` at depth 0 → `result` goes 0 when `d` is accepted; `err_underflow`=1 after the space. A later `begin end ` leaves `result`=0 and depth 0.
- `beginner begin1 _end end_ ` → depth stays 0 throughout; `result` is 1 after every delimiter.
- DEPTH_W=2, MAX_DEPTH=2: `begin begin begin ` → depth 2 and `err_overflow`=1 after the third space; then `clear` → depth 0, flags 0, `result`=1.
- `begin` with `in_valid` low for 5 cycles mid-word (between `g` and `i`) → identical outputs to a gapless run; `result`=0 once `n` is accepted, and stays 0 after the following space.
- Assert `reset_n` low for 1 cycle after `be` → all outputs at reset values. `gin ` that follows counts as a non-keyword; depth 0, `result`=1.
